// File: rtl/io_event_arbiter.sv
// Round-robin arbiter that funnels one-cycle event pulses from N_SRC sources into a
// small FIFO presented to the CPU as a level interrupt. Optional: IRQ_ACK_TIMEOUT_EN.
module io_event_arbiter #(
    parameter int N_SRC   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     i_src_irq,
    input  logic [32*N_SRC-1:0]  i_src_data,
    input  logic                 i_cpu_ack,
    output logic                 o_cpu_irq,
    output logic [31:0]          o_cpu_data,
    output logic [2:0]           o_cpu_src,
    output logic [4:0]           o_fifo_count,
    output logic [7:0]           o_drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]  src;
        logic [31:0] data;
    } entry_t;

    if (N_SRC < 2 || N_SRC > 8 || DEPTH < 2 || DEPTH > 16 ||
        (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_param
        $error("io_event_arbiter: parameter out of range");
    end

    // Per-source holding latches
    logic [N_SRC-1:0] r_hold_valid;
    logic [31:0]      r_hold_data [N_SRC];
    logic [2:0]       r_rr_ptr;

    // FIFO state
    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [4:0]       r_count;
    logic             r_cpu_irq;
    entry_t           r_head;
    logic [7:0]       r_drop;

    logic             w_grant_valid;
    logic [2:0]       w_grant_idx;
    logic             w_push;
    logic             w_pop;
    logic             w_to_pop;
    logic             w_to_drop;
    logic [31:0]      w_push_data;
    entry_t           w_push_entry;
    logic [4:0]       w_count_next;
    logic [PTR_W-1:0] w_rd_next;
    logic [3:0]       w_drop_num;
    logic [8:0]       w_drop_sum;

`ifdef IRQ_ACK_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    // The counter only advances while a word is waiting, so its value is the head's age.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_pop || r_count == 5'd0) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign w_to_pop  = (r_count != 5'd0) && (r_to_cnt == 16'(TIMEOUT - 1));
    assign w_to_drop = w_to_pop && !i_cpu_ack;
`else
    assign w_to_pop  = 1'b0;
    assign w_to_drop = 1'b0;
`endif

    assign w_pop  = (i_cpu_ack || w_to_pop) && (r_count != 5'd0);
    assign w_push = w_grant_valid && ((r_count < 5'(DEPTH)) || w_pop);

    // Round-robin search: the first valid source at or after r_rr_ptr wins.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (!w_grant_valid && r_hold_valid[i] &&
                    ((int'(r_rr_ptr) + k) % N_SRC) == i) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_push_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_grant_idx == 3'(i)) begin
                w_push_data = r_hold_data[i];
            end
        end
    end

    assign w_push_entry = '{src: w_grant_idx, data: w_push_data};

    // A drop is a pulse landing on a full latch that is not being drained this cycle.
    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (i_src_irq[i] && r_hold_valid[i] &&
                !(w_push && w_grant_idx == 3'(i))) begin
                w_drop_num = w_drop_num + 4'd1;
            end
        end
        if (w_to_drop) begin
            w_drop_num = w_drop_num + 4'd1;
        end
    end

    assign w_drop_sum = {1'b0, r_drop} + 9'(w_drop_num);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= '0;
            r_rr_ptr     <= '0;
            r_drop       <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (i_src_irq[i]) begin
                    r_hold_valid[i] <= 1'b1;
                end else if (w_push && w_grant_idx == 3'(i)) begin
                    r_hold_valid[i] <= 1'b0;
                end
            end
            if (w_push) begin
                r_rr_ptr <= (w_grant_idx == 3'(N_SRC - 1)) ? 3'd0 : w_grant_idx + 3'd1;
            end
            r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    // NOTE: data storage has no reset; the valid bits and FIFO count decide what is meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (i_src_irq[i]) begin
                r_hold_data[i] <= i_src_data[32*i +: 32];
            end
        end
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    assign w_count_next = r_count + {4'd0, w_push} - {4'd0, w_pop};
    assign w_rd_next    = r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_cpu_irq <= 1'b0;
            r_head    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count   <= w_count_next;
            r_cpu_irq <= (w_count_next != 5'd0);
            // Head register tracks the word at the read pointer; it holds when the FIFO drains.
            if (w_pop) begin
                if (r_count > 5'd1) begin
                    r_head <= r_mem[w_rd_next];
                end else if (w_push) begin
                    r_head <= w_push_entry;
                end
            end else if (r_count == 5'd0 && w_push) begin
                r_head <= w_push_entry;
            end
        end
    end

    assign o_cpu_irq    = r_cpu_irq;
    assign o_cpu_data   = r_head.data;
    assign o_cpu_src    = r_head.src;
    assign o_fifo_count = r_count;
    assign o_drop_cnt   = r_drop;

endmodule

// File: tb/tb_io_event_arbiter.sv
// Directed bench for io_event_arbiter: table of per-cycle vectors plus hand-written
// sequences for mid-burst reset and drop-counter saturation.
module tb_io_event_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   src_irq;
    logic [127:0] src_data;
    logic         cpu_ack;
    logic         cpu_irq;
    logic [31:0]  cpu_data;
    logic [2:0]   cpu_src;
    logic [4:0]   fifo_count;
    logic [7:0]   drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    io_event_arbiter #(.N_SRC(4), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_src_irq    (src_irq),
        .i_src_data   (src_data),
        .i_cpu_ack    (cpu_ack),
        .o_cpu_irq    (cpu_irq),
        .o_cpu_data   (cpu_data),
        .o_cpu_src    (cpu_src),
        .o_fifo_count (fifo_count),
        .o_drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   irq;
        logic [127:0] data;
        logic         ack;
        logic         e_irq;
        logic [31:0]  e_data;
        logic [2:0]   e_src;
        logic [4:0]   e_cnt;
        logic [7:0]   e_drop;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic [3:0] irq, input logic [127:0] data,
                                input logic ack, input logic e_irq,
                                input logic [31:0] e_data, input logic [2:0] e_src,
                                input logic [4:0] e_cnt, input logic [7:0] e_drop);
        vec_t v;
        v.irq = irq; v.data = data; v.ack = ack; v.e_irq = e_irq;
        v.e_data = e_data; v.e_src = e_src; v.e_cnt = e_cnt; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic e_irq, input logic [31:0] e_data,
                              input logic [2:0] e_src, input logic [4:0] e_cnt,
                              input logic [7:0] e_drop);
        check({tag, " cpu_irq"},    {31'd0, cpu_irq},   {31'd0, e_irq});
        check({tag, " cpu_data"},   cpu_data,           e_data);
        check({tag, " cpu_src"},    {29'd0, cpu_src},   {29'd0, e_src});
        check({tag, " fifo_count"}, {27'd0, fifo_count}, {27'd0, e_cnt});
        check({tag, " drop_cnt"},   {24'd0, drop_cnt},  {24'd0, e_drop});
    endtask

    localparam logic [127:0] W1  = 128'h00000000_00000000_01000003_00000000;
    localparam logic [127:0] W3  = 128'h00000033_00000000_00000000_00000000;
    localparam logic [127:0] WA  = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] WB0 = 128'h00000000_000000B0_00000000_00000000;
    localparam logic [127:0] WB1 = 128'h00000000_000000B1_00000000_00000000;
    localparam logic [127:0] WC0 = 128'h00000000_00000000_00000000_000000C0;
    localparam logic [127:0] WD  = 128'h000000D3_000000D2_000000D1_000000D0;
    localparam logic [127:0] WE  = 128'h000000E3_000000E2_000000E1_000000E0;
    localparam logic [127:0] WF  = 128'h000000F3_000000F2_000000F1_000000F0;

    initial begin
        // Single event, latency and ack
        tbl[0]  = mk(4'b0010, W1,  1'b0, 1'b0, 32'h0,        3'd0, 5'd0, 8'd0);
        tbl[1]  = mk(4'b0000, '0,  1'b0, 1'b1, 32'h01000003, 3'd1, 5'd1, 8'd0);
        tbl[2]  = mk(4'b0000, '0,  1'b1, 1'b0, 32'h01000003, 3'd1, 5'd0, 8'd0);
        // Source 3 event moves the round-robin pointer back to 0
        tbl[3]  = mk(4'b1000, W3,  1'b0, 1'b0, 32'h01000003, 3'd1, 5'd0, 8'd0);
        tbl[4]  = mk(4'b0000, '0,  1'b0, 1'b1, 32'h00000033, 3'd3, 5'd1, 8'd0);
        tbl[5]  = mk(4'b0000, '0,  1'b1, 1'b0, 32'h00000033, 3'd3, 5'd0, 8'd0);
        // All four sources at once, drained in order 0..3 until full
        tbl[6]  = mk(4'b1111, WA,  1'b0, 1'b0, 32'h00000033, 3'd3, 5'd0, 8'd0);
        tbl[7]  = mk(4'b0000, '0,  1'b0, 1'b1, 32'h000000A0, 3'd0, 5'd1, 8'd0);
        tbl[8]  = mk(4'b0000, '0,  1'b0, 1'b1, 32'h000000A0, 3'd0, 5'd2, 8'd0);
        tbl[9]  = mk(4'b0000, '0,  1'b0, 1'b1, 32'h000000A0, 3'd0, 5'd3, 8'd0);
        tbl[10] = mk(4'b0000, '0,  1'b0, 1'b1, 32'h000000A0, 3'd0, 5'd4, 8'd0);
        // Full FIFO: source 2 overwritten, then ack lets the newest word in
        tbl[11] = mk(4'b0100, WB0, 1'b0, 1'b1, 32'h000000A0, 3'd0, 5'd4, 8'd0);
        tbl[12] = mk(4'b0100, WB1, 1'b0, 1'b1, 32'h000000A0, 3'd0, 5'd4, 8'd1);
        tbl[13] = mk(4'b0000, '0,  1'b1, 1'b1, 32'h000000A1, 3'd1, 5'd4, 8'd1);
        // Full FIFO: ack coincides with a pending latch
        tbl[14] = mk(4'b0001, WC0, 1'b0, 1'b1, 32'h000000A1, 3'd1, 5'd4, 8'd1);
        tbl[15] = mk(4'b0000, '0,  1'b1, 1'b1, 32'h000000A2, 3'd2, 5'd4, 8'd1);
        // Drain: A3, B1 (src 2), C0 (src 0), then empty and a stray ack
        tbl[16] = mk(4'b0000, '0,  1'b1, 1'b1, 32'h000000A3, 3'd3, 5'd3, 8'd1);
        tbl[17] = mk(4'b0000, '0,  1'b1, 1'b1, 32'h000000B1, 3'd2, 5'd2, 8'd1);
        tbl[18] = mk(4'b0000, '0,  1'b1, 1'b1, 32'h000000C0, 3'd0, 5'd1, 8'd1);
        tbl[19] = mk(4'b0000, '0,  1'b1, 1'b0, 32'h000000C0, 3'd0, 5'd0, 8'd1);
        tbl[20] = mk(4'b0000, '0,  1'b1, 1'b0, 32'h000000C0, 3'd0, 5'd0, 8'd1);

        rst      = 1'b1;
        src_irq  = '0;
        src_data = '0;
        cpu_ack  = 1'b0;
        repeat (3) tick();
        check_outs("reset", 1'b0, 32'h0, 3'd0, 5'd0, 8'd0);
        rst = 1'b0;
        tick();
        check_outs("idle", 1'b0, 32'h0, 3'd0, 5'd0, 8'd0);

        for (int i = 0; i < 21; i++) begin
            src_irq  = tbl[i].irq;
            src_data = tbl[i].data;
            cpu_ack  = tbl[i].ack;
            tick();
            check_outs($sformatf("v%0d", i), tbl[i].e_irq, tbl[i].e_data, tbl[i].e_src,
                       tbl[i].e_cnt, tbl[i].e_drop);
        end

        // Mid-burst reset with three words queued and one latch still pending
        src_irq  = 4'b1111;
        src_data = WD;
        cpu_ack  = 1'b0;
        tick();
        src_irq = '0;
        repeat (3) tick();
        check("burst fifo_count", {27'd0, fifo_count}, 32'd3);
        rst = 1'b1;
        #1;
        check_outs("async reset", 1'b0, 32'h0, 3'd0, 5'd0, 8'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("post-reset %0d cpu_irq", i), {31'd0, cpu_irq}, 32'd0);
        end
        check("post-reset fifo_count", {27'd0, fifo_count}, 32'd0);

        // Fill the FIFO, then build up and saturate the drop counter
        src_irq  = 4'b1111;
        src_data = WE;
        tick();
        src_irq = '0;
        repeat (4) tick();
        check_outs("fill", 1'b1, 32'h000000E0, 3'd0, 5'd4, 8'd0);
        src_irq  = 4'b1111;
        src_data = WF;
        tick();
        check("latch load drop_cnt", {24'd0, drop_cnt}, 32'd0);
        tick();
        check("multi drop drop_cnt", {24'd0, drop_cnt}, 32'd4);
        src_irq = 4'b0010;
        for (int i = 0; i < 300; i++) tick();
        src_irq = '0;
        check("saturated drop_cnt", {24'd0, drop_cnt}, 32'd255);
        tick();
        check("saturated hold drop_cnt", {24'd0, drop_cnt}, 32'd255);
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        check_outs("pop after sat", 1'b1, 32'h000000E1, 3'd1, 5'd4, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
